// File: rtl/store_data_aligner.sv
// MEM-stage store aligner: truncates SB/SH/SW data onto byte lanes with enables
// and queues word writes in a FIFO that drains over valid/ready. Optional macro
// STORE_MISALIGN_EXC_EN rejects misaligned stores and pulses st_err instead.
module store_data_aligner #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [1:0]             st_size,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   q_empty
`ifdef STORE_MISALIGN_EXC_EN
    ,
    output logic                   st_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   lane_data;
    logic [3:0]    lane_be;
    logic          push, pop;

    // Each byte lane picks its source byte and enable from size and offset.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_data[8*i+:8] = (st_size == 2'b00) ? st_data[7:0] :
                                   (st_size == 2'b01) ? st_data[8*(i%2)+:8] :
                                                        st_data[8*i+:8];
        assign lane_be[i] = (st_size == 2'b00) ? (st_addr[1:0] == 2'(i)) :
                            (st_size == 2'b01) ? (st_addr[1] == 1'(i/2)) :
                                                 1'b1;
    end

`ifdef STORE_MISALIGN_EXC_EN
    logic mis;
    assign mis  = (st_size == 2'b01) ? st_addr[0] :
                  st_size[1]         ? (|st_addr[1:0]) : 1'b0;
    assign push = st_valid && st_ready && !mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_err <= 1'b0;
        else     st_err <= st_valid && st_ready && mis;
    end
`else
    assign push = st_valid && st_ready;
`endif

    assign pop       = mem_valid && mem_ready;
    assign st_ready  = (count != FULL);
    assign mem_valid = (count != '0);
    assign q_empty   = (count == '0);
    assign q_count   = count;
    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    assign mem_be    = be_q[rd_ptr];

    // Storage is cleared on reset so the mem_* outputs read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
                be_q[k]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= {st_addr[AW-1:2], 2'b00};
                data_q[wr_ptr] <= lane_data;
                be_q[wr_ptr]   <= lane_be;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (!push && pop)
                count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: tb/tb_store_data_aligner.sv
// Bench for store_data_aligner: directed steps plus random traffic, checked
// against a queue-based reference model of the store FIFO.
module tb_store_data_aligner;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [1:0]    st_size = 2'b00;
    logic [AW-1:0] st_addr = '0;
    logic [31:0]   st_data = '0;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [2:0]    q_count;
    logic          q_empty;
    logic          st_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    ent_t head;

    store_data_aligner #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .q_count(q_count), .q_empty(q_empty)
`ifdef STORE_MISALIGN_EXC_EN
        , .st_err(st_err)
`endif
    );

`ifndef STORE_MISALIGN_EXC_EN
    assign st_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference: what a store should look like in memory, from size and offset.
    function automatic ent_t mk(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        int off;
        off = int'(a % 4);
        e.addr = a - 32'(off);
        case (sz)
            2'd0: begin
                e.wdata = {24'h0, d[7:0]} * 32'h01010101;
                e.be    = 4'(1 << off);
            end
            2'd1: begin
                e.wdata = {16'h0, d[15:0]} * 32'h00010001;
                e.be    = (off >= 2) ? 4'hC : 4'h3;
            end
            default: begin
                e.wdata = d;
                e.be    = 4'hF;
            end
        endcase
        return e;
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // One clock: check state against model, advance model across the edge.
    task automatic cyc();
        bit push, pop, err;
        ent_t e;
        #1;
        check("st_ready", st_ready, q.size() < DEPTH);
        check("mem_valid", mem_valid, q.size() != 0);
        check("q_count", q_count, q.size());
        if (q.size() != 0) begin
            check("mem_addr", mem_addr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].wdata);
            check("mem_be", mem_be, q[0].be);
        end
        e    = mk(st_size, st_addr, st_data);
        push = st_valid && (q.size() < DEPTH);
        err  = 1'b0;
`ifdef STORE_MISALIGN_EXC_EN
        err  = push && misal(st_size, st_addr);
        push = push && !err;
`endif
        pop = mem_ready && (q.size() != 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge clk);
`ifdef STORE_MISALIGN_EXC_EN
        check("st_err", st_err, err);
`endif
    endtask

    task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_q_count", q_count, 0);
        check("rst_q_empty", q_empty, 1);
        check("rst_st_ready", st_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_st_err", st_err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Byte store
        mem_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h1003, 32'hDEADBEEF);
        cyc();
        check("sb_valid", mem_valid, 1);
        check("sb_addr", mem_addr, 32'h1000);
        check("sb_wdata", mem_wdata, 32'hEFEFEFEF);
        check("sb_be", mem_be, 4'b1000);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        cyc();
        check("sb_empty", q_empty, 1);

        // Half store
        drive(1'b1, 2'b01, 32'h2002, 32'h12345678);
        cyc();
        check("sh_addr", mem_addr, 32'h2000);
        check("sh_wdata", mem_wdata, 32'h56785678);
        check("sh_be", mem_be, 4'b1100);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        cyc();

        // Misaligned word
        mem_ready = 1'b0;
        drive(1'b1, 2'b10, 32'h3001, 32'hCAFEF00D);
        cyc();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef STORE_MISALIGN_EXC_EN
        check("mis_err", st_err, 1);
        check("mis_count", q_count, 0);
        cyc();
        check("mis_err_clr", st_err, 0);
`else
        check("mis_addr", mem_addr, 32'h3000);
        check("mis_be", mem_be, 4'b1111);
        check("mis_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
`endif

        // Backpressure / full
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, $urandom & 32'hFFFF_FFFC, $urandom);
            cyc();
        end
        check("full_count", q_count, DEPTH);
        check("full_ready", st_ready, 0);
        head = q[0];
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_wdata", mem_wdata, head.wdata);
            check("hold_addr", mem_addr, head.addr);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("drain_empty", q_empty, 1);

        // Simultaneous push/pop at q_count=2
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'($urandom_range(0, 2)), $urandom, $urandom);
            cyc();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, $urandom & 32'hFFFF_FFFC, $urandom);
            cyc();
            check("pp_count", q_count, 2);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        cyc();
        cyc();
        check("pp_empty", q_empty, 1);

        // Async reset mid-cycle with 3 entries queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, $urandom & 32'hFFFF_FFFC, $urandom);
            cyc();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("pre_rst_count", q_count, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", mem_valid, 0);
        check("arst_count", q_count, 0);
        check("arst_ready", st_ready, 1);
        check("arst_wdata", mem_wdata, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        mem_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cyc();
        check("end_empty", q_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
